// File: rtl/button_conditioner_pkg.sv
// Purpose : shared state encoding and default timing constants for the button conditioner.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package button_conditioner_pkg;

   // Defaults assume a 50 MHz clock: 1 ms debounce, 0.5 s long-press threshold.
   localparam int DEF_N_BUTTONS       = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_LONG_CYCLES     = 25000000;
   localparam int DEF_CNT_W           = 25;

   typedef enum logic [1:0] {
      BTN_IDLE = 2'd0,
      BTN_HELD = 2'd1,
      BTN_LONG = 2'd2
   } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// Purpose : one button: 2-flop synchroniser, debounce counter and IDLE/HELD/LONG press classifier.
// Latency : raw change sampled at edge 0 shows on pressed after edge DEBOUNCE_CYCLES+1; pulses are registered.
// Backpressure: none; free-running, every event is reported exactly once.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   btn_n                      raw button, active-low, asynchronous to clk
//   pressed / long_press       debounced level / long-hold level
//   press_edge / short_release / long_edge   single-cycle registered pulses
module button_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic pressed,
   output logic press_edge,
   output logic short_release,
   output logic long_press,
   output logic long_edge
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       sync_q;
   logic             s;
   logic             stable;
   logic [CNT_W-1:0] deb_cnt;
   logic             accept;
   logic             rise;
   logic             fall;

   btn_state_t       state, state_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic             press_edge_q, press_edge_nxt;
   logic             short_release_q, short_release_nxt;
   logic             long_edge_q, long_edge_nxt;

   // Synchroniser: raw level is inverted so 1 = held from here on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], ~btn_n};
      end
   end

   assign s = sync_q[1];

   // The classifier reacts to the edge on which stable is about to change so
   // that press_edge and the long_press fall line up with pressed itself.
   always_comb begin
      accept = (s != stable) && (deb_cnt == DEB_LAST);
      rise   = accept && s;
      fall   = accept && !s;
   end

   // Debounce: any cycle where s agrees with stable restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable  <= 1'b0;
         deb_cnt <= '0;
      end else if (s == stable) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         stable  <= s;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= BTN_IDLE;
         hold_cnt        <= '0;
         press_edge_q    <= 1'b0;
         short_release_q <= 1'b0;
         long_edge_q     <= 1'b0;
      end else begin
         state           <= state_nxt;
         hold_cnt        <= hold_nxt;
         press_edge_q    <= press_edge_nxt;
         short_release_q <= short_release_nxt;
         long_edge_q     <= long_edge_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      hold_nxt          = hold_cnt;
      press_edge_nxt    = 1'b0;
      short_release_nxt = 1'b0;
      long_edge_nxt     = 1'b0;
      case (state)
         BTN_IDLE: begin
            if (rise) begin
               state_nxt      = BTN_HELD;
               press_edge_nxt = 1'b1;
               hold_nxt       = '0;
            end
         end
         BTN_HELD: begin
            // A release on the threshold edge wins, so long_press never
            // outlives pressed.
            if (fall) begin
               state_nxt         = BTN_IDLE;
               short_release_nxt = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt     = BTN_LONG;
               long_edge_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + CNT_ONE;
            end
         end
         BTN_LONG: begin
            if (fall) begin
               state_nxt = BTN_IDLE;
            end
         end
         default: begin
            state_nxt = BTN_IDLE;
         end
      endcase
   end

   assign pressed       = stable;
   assign press_edge    = press_edge_q;
   assign short_release = short_release_q;
   assign long_press    = (state == BTN_LONG);
   assign long_edge     = long_edge_q;

endmodule

// File: rtl/button_conditioner.sv
// Purpose : conditions N_BUTTONS raw push-buttons into debounced levels and press/release/long events.
// Latency : DEBOUNCE_CYCLES+2 cycles from raw change to pressed; long_edge LONG_CYCLES after press_edge.
// Backpressure: none; outputs are levels and single-cycle pulses.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   btn_n            raw buttons, active-low, asynchronous
//   pressed, long_press                      per-button levels
//   press_edge, short_release, long_edge     per-button single-cycle pulses
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int N_BUTTONS       = DEF_N_BUTTONS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] btn_n,
   output logic [N_BUTTONS-1:0] pressed,
   output logic [N_BUTTONS-1:0] press_edge,
   output logic [N_BUTTONS-1:0] short_release,
   output logic [N_BUTTONS-1:0] long_press,
   output logic [N_BUTTONS-1:0] long_edge
);

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .btn_n         (btn_n[i]),
         .pressed       (pressed[i]),
         .press_edge    (press_edge[i]),
         .short_release (short_release[i]),
         .long_press    (long_press[i]),
         .long_edge     (long_edge[i])
      );
   end

endmodule
